// File: rtl/bus_arbiter_rr.sv
// Two-device round-robin bus arbiter with registered, mutually exclusive grants,
// per-owner hold limit with preemption, and dead cycles between owners.
module bus_arbiter_rr #(
  parameter int MAX_HOLD    = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_in1,
  input  logic       req_in2,
  output logic       gnt1,
  output logic       gnt2,
  output logic [1:0] owner,
  output logic [3:0] hold_cnt,
  output logic       preempt
);

  typedef enum logic [1:0] {IDLE, GNT1, GNT2, TURN} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
  localparam logic [1:0] TURN_N   = 2'(TURN_CYCLES);

  state_t     state, state_nx;
  logic       last2, last2_nx;
  logic [1:0] turn_cnt, turn_cnt_nx;
  logic [3:0] hold_nx;
  logic       preempt_nx;
  logic       leave;
  logic       leave_last2;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= HOLD_MAX) ? HOLD_MAX : v + 4'd1;
  endfunction

  // On a tie the device that was not served last wins; last2 set means device 2.
  function automatic state_t arbitrate(input logic r1, input logic r2, input logic l2);
    if (r1 && r2) return l2 ? GNT1 : GNT2;
    if (r1)       return GNT1;
    if (r2)       return GNT2;
    return IDLE;
  endfunction

  function automatic logic [3:0] first_hold(input state_t s);
    return (s == GNT1 || s == GNT2) ? 4'd1 : 4'd0;
  endfunction

  always_comb begin
    state_nx    = state;
    last2_nx    = last2;
    turn_cnt_nx = turn_cnt;
    hold_nx     = hold_cnt;
    preempt_nx  = 1'b0;
    leave       = 1'b0;
    leave_last2 = last2;
    case (state)
      IDLE: begin
        state_nx = arbitrate(req_in1, req_in2, last2);
        hold_nx  = first_hold(state_nx);
      end
      GNT1: begin
        leave       = !req_in1 || (hold_cnt == HOLD_MAX && req_in2);
        leave_last2 = 1'b0;
        preempt_nx  = req_in1 && leave;
      end
      GNT2: begin
        leave       = !req_in2 || (hold_cnt == HOLD_MAX && req_in1);
        leave_last2 = 1'b1;
        preempt_nx  = req_in2 && leave;
      end
      TURN: begin
        if (turn_cnt <= 2'd1) begin
          state_nx = arbitrate(req_in1, req_in2, last2);
          hold_nx  = first_hold(state_nx);
        end else begin
          turn_cnt_nx = turn_cnt - 2'd1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (state == GNT1 || state == GNT2) begin
      if (leave) begin
        last2_nx = leave_last2;
        if (TURN_N != 2'd0) begin
          state_nx    = TURN;
          turn_cnt_nx = TURN_N;
          hold_nx     = 4'd0;
        end else begin
          // Zero turnaround: the next owner is chosen at the same edge.
          state_nx = arbitrate(req_in1, req_in2, leave_last2);
          hold_nx  = first_hold(state_nx);
        end
      end else begin
        hold_nx = sat_inc(hold_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last2    <= 1'b1;
      turn_cnt <= 2'd0;
      gnt1     <= 1'b0;
      gnt2     <= 1'b0;
      hold_cnt <= 4'd0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nx;
      last2    <= last2_nx;
      turn_cnt <= turn_cnt_nx;
      gnt1     <= (state_nx == GNT1);
      gnt2     <= (state_nx == GNT2);
      hold_cnt <= hold_nx;
      preempt  <= preempt_nx;
    end
  end

  assign owner = {gnt2, gnt1};

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: default instance plus a zero-turnaround instance.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       r1 = 1'b1, r2 = 1'b1;
  logic       z1 = 1'b0, z2 = 1'b0;
  logic       gnt1, gnt2, preempt;
  logic [1:0] owner;
  logic [3:0] hold_cnt;
  logic       zg1, zg2, zpre;
  logic [1:0] zown;
  logic [3:0] zhold;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.MAX_HOLD(4), .TURN_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_in1(r1), .req_in2(r2),
    .gnt1(gnt1), .gnt2(gnt2), .owner(owner), .hold_cnt(hold_cnt), .preempt(preempt)
  );

  bus_arbiter_rr #(.MAX_HOLD(4), .TURN_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_in1(z1), .req_in2(z2),
    .gnt1(zg1), .gnt2(zg2), .owner(zown), .hold_cnt(zhold), .preempt(zpre)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Both requesting after the first gnt1 cycle: h2..h4, dead, gnt2 x4, dead, gnt1 x4.
  int exp_own[13]  = '{1, 1, 1, 0, 2, 2, 2, 2, 0, 1, 1, 1, 1};
  int exp_hold[13] = '{2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
  int exp_pre[13]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  int z_own[9]     = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
  int z_hold[9]    = '{1, 2, 3, 4, 1, 2, 3, 4, 1};
  int z_pre[9]     = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    // Reset held with both requests high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_owner", owner, 0);
      chk("rst_hold", hold_cnt, 0);
      chk("rst_pre", preempt, 0);
    end
    rst = 1'b0;
    tick();
    chk("first_gnt1", gnt1, 1);
    chk("first_owner", owner, 1);
    chk("first_hold", hold_cnt, 1);

    // Continuous contention.
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("rr_owner", owner, exp_own[i]);
      chk("rr_hold", hold_cnt, exp_hold[i]);
      chk("rr_pre", preempt, exp_pre[i]);
      chk("rr_excl", gnt1 & gnt2, 0);
    end

    // Sole requester holds indefinitely.
    r1 = 1'b0; r2 = 1'b0;
    do_reset();
    r1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("solo_gnt1", gnt1, 1);
      chk("solo_hold", hold_cnt, (i < 3) ? i + 1 : 4);
      chk("solo_pre", preempt, 0);
    end
    r1 = 1'b0;
    tick();
    chk("rel_gnt1", gnt1, 0);
    chk("rel_pre", preempt, 0);
    tick();
    chk("rel_idle_owner", owner, 0);
    chk("rel_idle_hold", hold_cnt, 0);
    r1 = 1'b1;
    tick();
    chk("regrant_owner", owner, 1);

    // Release under contention after two grant cycles.
    r1 = 1'b1; r2 = 1'b1;
    do_reset();
    tick();
    chk("rel2_h1", hold_cnt, 1);
    tick();
    chk("rel2_h2", hold_cnt, 2);
    r1 = 1'b0;
    tick();
    chk("rel2_dead_owner", owner, 0);
    chk("rel2_dead_pre", preempt, 0);
    tick();
    chk("rel2_gnt2", gnt2, 1);
    chk("rel2_hold", hold_cnt, 1);

    // Reset pulse in the middle of a gnt2 hold.
    r1 = 1'b1; r2 = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    chk("mid_owner", owner, 2);
    chk("mid_hold", hold_cnt, 3);
    rst = 1'b1;
    tick();
    chk("mid_rst_gnt2", gnt2, 0);
    chk("mid_rst_owner", owner, 0);
    rst = 1'b0;
    tick();
    chk("mid_after_owner", owner, 1);

    // Zero-turnaround instance.
    r1 = 1'b0; r2 = 1'b0;
    do_reset();
    z1 = 1'b1; z2 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("z_owner", zown, z_own[i]);
      chk("z_hold", zhold, z_hold[i]);
      chk("z_pre", zpre, z_pre[i]);
      chk("z_excl", zg1 & zg2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
